// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl -- mode sequencer for the LED up/down counter datapath.
//
// Turns a debounced button level into short/long press commands, runs the
// IDLE/UP/DOWN/PAUSE mode machine and issues a one-cycle step enable (tick)
// with a direction at a selectable rate. The counter is clocked by clk and
// steps only on tick. In bounce mode the counter value is read back, and the
// direction reverses at the end stops instead of letting the counter wrap.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-low reset
//   btn        debounced button level, synchronous to clk (1 = pressed)
//   spd_sel    rate select: 1 = FAST_DIV, 0 = SLOW_DIV cycles per tick
//   bounce_en  1 = reverse at the end stops, 0 = counter wraps
//   cnt_val    counter value fed back from the datapath
//   tick       one-cycle step enable
//   dir        step direction (1 = up, 0 = down), valid with tick
//   mode       00 IDLE, 01 UP, 10 DOWN, 11 PAUSE
//   running    1 while in UP or DOWN
module count_seq_ctrl #(
  parameter int CNT_W      = 4,
  parameter int SLOW_DIV   = 25000000,
  parameter int FAST_DIV   = 5000000,
  parameter int LONG_PRESS = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn,
  input  logic             spd_sel,
  input  logic             bounce_en,
  input  logic [CNT_W-1:0] cnt_val,
  output logic             tick,
  output logic             dir,
  output logic [1:0]       mode,
  output logic             running
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    UP    = 2'b01,
    DOWN  = 2'b10,
    PAUSE = 2'b11
  } state_t;

  localparam int DIV_MAX = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
  localparam int PW      = $clog2(DIV_MAX);
  localparam int TW      = $clog2(LONG_PRESS + 1);

  localparam logic [PW-1:0]    SLOW_LAST = PW'(SLOW_DIV - 1);
  localparam logic [PW-1:0]    FAST_LAST = PW'(FAST_DIV - 1);
  localparam logic [TW-1:0]    LONG_MAX  = TW'(LONG_PRESS);
  localparam logic [TW-1:0]    LONG_HIT  = TW'(LONG_PRESS - 1);
  localparam logic [CNT_W-1:0] CNT_TOP   = '1;

  state_t          state, state_nxt;
  logic [PW-1:0]   presc, presc_nxt;
  logic [TW-1:0]   timer;
  logic            btn_q;
  logic            armed;     // a press is in progress and has not yet produced an event
  logic            low_seen;  // btn has been seen released since reset
  logic            saved_up, saved_nxt;
  logic            tick_nxt, dir_nxt;

  logic            rise, released, short_ev, long_ev, press_ev, run, expire;
  logic [PW-1:0]   div_last;

  // A button already held when reset releases must not look like a new press,
  // so an edge only counts once a released level has been observed.
  assign rise     = btn & ~btn_q & low_seen;
  assign released = ~btn & btn_q;
  assign long_ev  = armed & btn & btn_q & (timer == LONG_HIT);
  assign short_ev = armed & released & (timer < LONG_HIT);
  assign press_ev = short_ev | long_ev;

  assign run      = (state == UP) || (state == DOWN);
  assign div_last = spd_sel ? FAST_LAST : SLOW_LAST;
  // >= rather than == so a switch to a shorter period mid-count expires at once
  assign expire   = run && (presc >= div_last);

  assign mode     = state;

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that left
    // one unassigned would infer a latch.
    state_nxt = state;
    presc_nxt = presc;
    saved_nxt = saved_up;
    tick_nxt  = 1'b0;
    dir_nxt   = dir;

    if (press_ev) begin
      // A press outranks a coincident expiry and is applied to the
      // pre-bounce state; the prescaler restarts with the new mode.
      presc_nxt = '0;
      unique case (state)
        IDLE: begin
          if (short_ev) state_nxt = UP;
        end
        UP: begin
          if (short_ev) begin
            state_nxt = DOWN;
          end else begin
            state_nxt = PAUSE;
            saved_nxt = 1'b1;
          end
        end
        DOWN: begin
          if (short_ev) begin
            state_nxt = UP;
          end else begin
            state_nxt = PAUSE;
            saved_nxt = 1'b0;
          end
        end
        PAUSE: begin
          if (short_ev) begin
            state_nxt = saved_up ? UP : DOWN;
          end else begin
            state_nxt = IDLE;
            saved_nxt = 1'b1;
            dir_nxt   = 1'b1;
          end
        end
      endcase
    end else if (expire) begin
      presc_nxt = '0;
      tick_nxt  = 1'b1;
      // At an end stop the reversal and its first step share one tick.
      if (bounce_en && (state == UP) && (cnt_val == CNT_TOP)) begin
        state_nxt = DOWN;
        dir_nxt   = 1'b0;
      end else if (bounce_en && (state == DOWN) && (cnt_val == '0)) begin
        state_nxt = UP;
        dir_nxt   = 1'b1;
      end else begin
        dir_nxt   = (state == UP);
      end
    end else if (run) begin
      presc_nxt = presc + 1'b1;
    end else begin
      presc_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the values from before this edge.
    if (!rst) begin
      state    <= IDLE;
      presc    <= '0;
      timer    <= '0;
      btn_q    <= 1'b0;
      armed    <= 1'b0;
      low_seen <= 1'b0;
      saved_up <= 1'b1;
      tick     <= 1'b0;
      dir      <= 1'b1;
      running  <= 1'b0;
    end else begin
      state    <= state_nxt;
      presc    <= presc_nxt;
      saved_up <= saved_nxt;
      tick     <= tick_nxt;
      dir      <= dir_nxt;
      running  <= (state_nxt == UP) || (state_nxt == DOWN);
      btn_q    <= btn;

      if (!btn) low_seen <= 1'b1;

      if (rise) begin
        timer <= '0;
      end else if (btn && (timer != LONG_MAX)) begin
        timer <= timer + 1'b1;
      end

      if (rise) begin
        armed <= 1'b1;
      end else if (press_ev || released) begin
        armed <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_count_seq_ctrl.sv
// tb_count_seq_ctrl -- self-checking bench for count_seq_ctrl.
//
// A table of button presses with their expected resulting modes, hand-written
// sequences for the timing corner cases, then randomized presses, rate changes,
// bounce settings and resets compared every cycle against a press-length based
// reference model. A small counter emulation closes the cnt_val loop.
module tb_count_seq_ctrl;

  localparam int CNT_W   = 4;
  localparam int SLOW    = 8;
  localparam int FAST    = 2;
  localparam int LONG    = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             btn = 1'b0;
  logic             spd_sel = 1'b0;
  logic             bounce_en = 1'b0;
  logic [CNT_W-1:0] cnt_val = '0;
  logic             tick, dir, running;
  logic [1:0]       mode;

  int n_cmp = 0;
  int n_bad = 0;
  bit auto_cnt = 1'b0;

  always #5 clk = ~clk;

  count_seq_ctrl #(
    .CNT_W(CNT_W), .SLOW_DIV(SLOW), .FAST_DIV(FAST), .LONG_PRESS(LONG)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn), .spd_sel(spd_sel), .bounce_en(bounce_en),
    .cnt_val(cnt_val), .tick(tick), .dir(dir), .mode(mode), .running(running)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Presses are judged by how many consecutive cycles btn was high: a release
  // after fewer than LONG high cycles is short; the (LONG+1)th high cycle is long.
  int m_mode, m_phase, m_held;
  bit m_tick, m_dir, m_saved_up, m_prev, m_low_seen, m_armed;

  task automatic model_reset();
    m_mode = 0; m_phase = 0; m_held = 0;
    m_tick = 0; m_dir = 1; m_saved_up = 1;
    m_prev = 0; m_low_seen = 0; m_armed = 0;
  endtask

  task automatic model_step(input bit b, input bit spd, input bit bnc, input int cnt);
    int div;
    bit short_ev, long_ev, run, expire;
    div = spd ? FAST : SLOW;
    short_ev = 0;
    long_ev  = 0;
    if (b && !m_prev && m_low_seen) begin
      m_armed = 1;
      m_held  = 1;
    end else if (b && m_prev && m_armed) begin
      m_held++;
      if (m_held == LONG + 1) begin
        long_ev = 1;
        m_armed = 0;
      end
    end else if (!b && m_prev && m_armed) begin
      if (m_held < LONG) short_ev = 1;
      m_armed = 0;
    end
    if (!b) m_low_seen = 1;
    m_prev = b;

    run    = (m_mode == 1) || (m_mode == 2);
    expire = run && (m_phase >= div - 1);
    m_tick = 0;
    if (short_ev || long_ev) begin
      m_phase = 0;
      case (m_mode)
        0: if (short_ev) m_mode = 1;
        1: if (short_ev) m_mode = 2; else begin m_mode = 3; m_saved_up = 1; end
        2: if (short_ev) m_mode = 1; else begin m_mode = 3; m_saved_up = 0; end
        default: if (short_ev) m_mode = m_saved_up ? 1 : 2;
                 else begin m_mode = 0; m_saved_up = 1; m_dir = 1; end
      endcase
    end else if (expire) begin
      m_phase = 0;
      m_tick  = 1;
      if (bnc && m_mode == 1 && cnt == CNT_MAX) begin
        m_mode = 2; m_dir = 0;
      end else if (bnc && m_mode == 2 && cnt == 0) begin
        m_mode = 1; m_dir = 1;
      end else begin
        m_dir = (m_mode == 1);
      end
    end else if (run) begin
      m_phase++;
    end else begin
      m_phase = 0;
    end
  endtask

  // One clock cycle with the currently driven inputs; sampled 1 time unit
  // after the rising edge and compared against the model.
  task automatic cyc();
    @(posedge clk);
    #1;
    model_step(btn, spd_sel, bounce_en, int'(cnt_val));
    if (auto_cnt && tick) cnt_val = dir ? cnt_val + 1'b1 : cnt_val - 1'b1;
    check("m_tick", tick, m_tick);
    check("m_dir", dir, m_dir);
    check("m_mode", mode, m_mode);
    check("m_running", running, (m_mode == 1 || m_mode == 2));
  endtask

  // Called at a sample point; asserts reset mid-cycle and checks that the
  // outputs clear without waiting for a clock edge.
  task automatic pulse_reset(input string name);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check({name, "_mode"}, mode, 0);
    check({name, "_tick"}, tick, 0);
    check({name, "_dir"}, dir, 1);
    check({name, "_running"}, running, 0);
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // btn high for n cycles, then one release cycle.
  task automatic press(input int n);
    btn = 1'b1;
    repeat (n) cyc();
    btn = 1'b0;
    cyc();
  endtask

  // Waits (bounded) for the next tick and checks its distance and outputs.
  task automatic wait_tick(input string name, input int exp_gap, input int exp_dir,
                           input int exp_mode);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (tick !== 1'b1 && n < exp_gap + 4);
    check({name, "_gap"}, n, exp_gap);
    check({name, "_dir"}, dir, exp_dir);
    check({name, "_mode"}, mode, exp_mode);
  endtask

  typedef struct {
    int hold;
    int exp_mode;
    int exp_running;
  } press_vec_t;

  press_vec_t tbl [12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{3,  1, 1};  // IDLE  -> UP
    tbl[1]  = '{1,  2, 1};  // UP    -> DOWN
    tbl[2]  = '{15, 1, 1};  // longest short press: DOWN -> UP
    tbl[3]  = '{17, 3, 0};  // shortest long press: UP -> PAUSE
    tbl[4]  = '{2,  1, 1};  // PAUSE -> saved UP
    tbl[5]  = '{3,  2, 1};  // UP    -> DOWN
    tbl[6]  = '{20, 3, 0};  // DOWN  -> PAUSE, release ignored
    tbl[7]  = '{4,  2, 1};  // PAUSE -> saved DOWN
    tbl[8]  = '{17, 3, 0};  // DOWN  -> PAUSE
    tbl[9]  = '{17, 0, 0};  // PAUSE -> IDLE
    tbl[10] = '{18, 0, 0};  // long press in IDLE stays IDLE
    tbl[11] = '{1,  1, 1};  // IDLE  -> UP

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("init_mode", mode, 0);
    check("init_tick", tick, 0);
    check("init_dir", dir, 1);
    check("init_running", running, 0);
    rst = 1'b1;
    repeat (2) cyc();

    // ---------------- press table ----------------
    for (int i = 0; i < 12; i++) begin
      press(tbl[i].hold);
      check($sformatf("tbl%0d_mode", i), mode, tbl[i].exp_mode);
      check($sformatf("tbl%0d_running", i), running, tbl[i].exp_running);
    end

    // ---------------- A: short press from reset, slow rate ----------------
    pulse_reset("a_rst");
    cyc();
    press(3);
    check("a_mode", mode, 1);
    check("a_running", running, 1);
    wait_tick("a_first", 8, 1, 1);
    wait_tick("a_second", 8, 1, 1);

    // ---------------- B: rate switch with prescaler at 5 ----------------
    repeat (5) cyc();
    spd_sel = 1'b1;
    wait_tick("b_switch", 1, 1, 1);
    wait_tick("b_fast", 2, 1, 1);
    spd_sel = 1'b0;

    // ---------------- C: long press in DOWN, resume, back to IDLE ----------------
    press(3);
    check("c_down", mode, 2);
    btn = 1'b1;
    repeat (16) cyc();
    check("c_before_long", mode, 2);
    cyc();
    check("c_long", mode, 3);
    repeat (3) begin
      cyc();
      check("c_hold_tick", tick, 0);
    end
    btn = 1'b0;
    cyc();
    check("c_release", mode, 3);
    repeat (10) cyc();
    press(3);
    check("c_resume_mode", mode, 2);
    wait_tick("c_resume", 8, 0, 2);
    press(17);
    check("c_pause2", mode, 3);
    press(17);
    check("c_idle_mode", mode, 0);
    check("c_idle_dir", dir, 1);

    // ---------------- D: bounce at the end stops ----------------
    bounce_en = 1'b1;
    cnt_val   = 4'(CNT_MAX);
    press(3);
    check("d_up", mode, 1);
    wait_tick("d_top", 8, 0, 2);
    cnt_val = '0;
    wait_tick("d_bot", 8, 1, 1);
    bounce_en = 1'b0;
    cnt_val   = 4'(CNT_MAX);
    wait_tick("d_wrap", 8, 1, 1);

    // ---------------- E: release on the expiry cycle ----------------
    repeat (4) cyc();
    btn = 1'b1;
    repeat (3) cyc();
    btn = 1'b0;
    cyc();
    check("e_tick", tick, 0);
    check("e_mode", mode, 2);
    wait_tick("e_next", 8, 0, 2);

    // ---------------- F: reset mid-press with btn held through release ----------------
    press(3);
    check("f_up", mode, 1);
    btn = 1'b1;
    repeat (5) cyc();
    pulse_reset("f_rst");
    repeat (20) cyc();
    check("f_held", mode, 0);
    btn = 1'b0;
    cyc();
    check("f_release", mode, 0);
    press(3);
    check("f_press", mode, 1);

    // ---------------- randomized run against the model ----------------
    pulse_reset("r_rst");
    cnt_val  = '0;
    auto_cnt = 1'b1;
    for (int seg = 0; seg < 150; seg++) begin
      int low_n, hi_n, pick;
      if ($urandom_range(0, 3) == 0) spd_sel = 1'($urandom_range(0, 1));
      bounce_en = ($urandom_range(0, 2) != 0);
      low_n = $urandom_range(1, 12);
      btn = 1'b0;
      repeat (low_n) cyc();
      pick = $urandom_range(0, 9);
      hi_n = (pick < 5) ? $urandom_range(1, 5) : (pick < 9) ? $urandom_range(14, 19) : 25;
      btn = 1'b1;
      for (int i = 0; i < hi_n; i++) begin
        cyc();
        if (i == hi_n / 2 && $urandom_range(0, 29) == 0) pulse_reset("r_mid_rst");
      end
      if ($urandom_range(0, 4) == 0) begin
        btn = 1'b0;
        repeat ($urandom_range(10, 40)) cyc();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
